// File: rtl/decode_pkg.sv
// Decode stage shared types: opcode map, instruction field offsets,
// and the pure opcode-to-control decode table.
package decode_pkg;

  localparam logic [3:0] OP_LDI = 4'd8;
  localparam logic [3:0] OP_JMP = 4'd9;
  localparam logic [3:0] OP_BZ  = 4'd10;
  localparam logic [3:0] OP_ST  = 4'd11;
  localparam logic [3:0] OP_LD  = 4'd12;
  localparam logic [3:0] OP_IL0 = 4'd13;
  localparam logic [3:0] OP_IL1 = 4'd14;
  localparam logic [3:0] OP_NOP = 4'd15;

  typedef struct packed {
    logic [3:0] alu_op;
    logic       use_dst;
    logic       use_src1;
    logic       use_src0;
    logic       use_imm;
    logic       reg_we;
    logic       mem_we;
    logic       sel1;
    logic       sel2;
    logic       pc_we;
    logic       illegal;
  } ctrl_t;

  function automatic int opc_hi(input int instr_w);
    return instr_w - 1;
  endfunction

  function automatic int dst_hi(input int instr_w);
    return instr_w - 5;
  endfunction

  function automatic int src1_hi(input int instr_w, input int reg_aw);
    return instr_w - 5 - reg_aw;
  endfunction

  function automatic int src0_hi(input int instr_w, input int reg_aw);
    return instr_w - 5 - 2 * reg_aw;
  endfunction

  function automatic ctrl_t decode(input logic [3:0] opc);
    ctrl_t c;
    c = '0;
    unique case (1'b1)
      !opc[3]: begin
        c.alu_op   = opc;
        c.use_dst  = 1'b1;
        c.use_src1 = 1'b1;
        c.use_src0 = 1'b1;
        c.reg_we   = 1'b1;
      end
      opc == OP_LDI: begin
        c.use_dst = 1'b1;
        c.use_imm = 1'b1;
        c.sel1    = 1'b1;
        c.reg_we  = 1'b1;
      end
      opc == OP_JMP: begin
        c.pc_we = 1'b1;
      end
      opc == OP_BZ: begin
        c.use_src1 = 1'b1;
        c.pc_we    = 1'b1;
      end
      opc == OP_ST: begin
        c.use_src1 = 1'b1;
        c.use_src0 = 1'b1;
        c.mem_we   = 1'b1;
      end
      opc == OP_LD: begin
        c.use_dst  = 1'b1;
        c.use_src1 = 1'b1;
        c.sel2     = 1'b1;
        c.reg_we   = 1'b1;
      end
      opc == OP_IL0 || opc == OP_IL1: begin
        c.illegal = 1'b1;
      end
      opc == OP_NOP: begin
        c = '0;
      end
    endcase
    return c;
  endfunction

endpackage

// File: rtl/decode_stage_scoreboard.sv
// Busy-bit tracker for in-flight register writes.
// A same-cycle set and clear of one register leaves it busy.
module reg_scoreboard #(
  parameter int REG_AW = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              set_en,
  input  logic [REG_AW-1:0] set_idx,
  input  logic              clr_en,
  input  logic [REG_AW-1:0] clr_idx,
  input  logic [REG_AW-1:0] rd0_idx,
  input  logic [REG_AW-1:0] rd1_idx,
  input  logic [REG_AW-1:0] wr_idx,
  output logic              rd0_busy,
  output logic              rd1_busy,
  output logic              wr_busy
);

  logic [2**REG_AW-1:0] busy;

  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= '0;
    end else begin
      if (clr_en) busy[clr_idx] <= 1'b0;
      if (set_en) busy[set_idx] <= 1'b1;
    end
  end

  assign rd0_busy = busy[rd0_idx];
  assign rd1_busy = busy[rd1_idx];
  assign wr_busy  = busy[wr_idx];

endmodule

// File: rtl/decode_stage.sv
// Registered instruction decode with valid/ready handshake and
// RAW/WAW interlock against in-flight register writes.
module decode_stage
  import decode_pkg::*;
#(
  parameter int INSTR_W = 32,
  parameter int REG_AW  = 4,
  parameter int IMM_W   = 16,
  parameter int DATA_W  = 40
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] op,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [3:0]         alu_op,
  output logic [REG_AW-1:0]  dst,
  output logic [REG_AW-1:0]  src1,
  output logic [REG_AW-1:0]  src0,
  output logic               reg_we,
  output logic               mem_we,
  output logic               sel1,
  output logic               sel2,
  output logic               pc_we,
  output logic [IMM_W-1:0]   pc_in,
  output logic [DATA_W-1:0]  data,
  output logic               illegal,
  input  logic               wb_valid,
  input  logic [REG_AW-1:0]  wb_dst
);

  localparam int OH  = opc_hi(INSTR_W);
  localparam int DH  = dst_hi(INSTR_W);
  localparam int S1H = src1_hi(INSTR_W, REG_AW);
  localparam int S0H = src0_hi(INSTR_W, REG_AW);

  logic [3:0]        f_opc;
  logic [REG_AW-1:0] f_dst;
  logic [REG_AW-1:0] f_src1;
  logic [REG_AW-1:0] f_src0;
  logic [IMM_W-1:0]  f_imm;
  ctrl_t             c;

  assign f_opc  = op[OH -: 4];
  assign f_dst  = op[DH -: REG_AW];
  assign f_src1 = op[S1H -: REG_AW];
  assign f_src0 = op[S0H -: REG_AW];
  assign f_imm  = op[IMM_W-1:0];
  assign c      = decode(f_opc);

  logic busy1, busy0, busyd;
  logic clr1, clr0, clrd;
  logic hazard, accept;

  // A retiring writeback this cycle already frees its register.
  assign clr1 = wb_valid && (wb_dst == f_src1);
  assign clr0 = wb_valid && (wb_dst == f_src0);
  assign clrd = wb_valid && (wb_dst == f_dst);

  assign hazard = in_valid &
    ((c.use_src1 & busy1 & ~clr1) |
     (c.use_src0 & busy0 & ~clr0) |
     (c.reg_we   & busyd & ~clrd));

  assign in_ready = ~rst & ~hazard & (~out_valid | out_ready);
  assign accept   = in_valid & in_ready;

  reg_scoreboard #(
    .REG_AW(REG_AW)
  ) u_sb (
    .clk     (clk),
    .rst     (rst),
    .set_en  (accept & c.reg_we),
    .set_idx (f_dst),
    .clr_en  (wb_valid),
    .clr_idx (wb_dst),
    .rd0_idx (f_src1),
    .rd1_idx (f_src0),
    .wr_idx  (f_dst),
    .rd0_busy(busy1),
    .rd1_busy(busy0),
    .wr_busy (busyd)
  );

  always_ff @(posedge clk) begin
    if (rst || (!accept && out_ready)) begin
      out_valid <= 1'b0;
      alu_op    <= '0;
      dst       <= '0;
      src1      <= '0;
      src0      <= '0;
      reg_we    <= 1'b0;
      mem_we    <= 1'b0;
      sel1      <= 1'b0;
      sel2      <= 1'b0;
      pc_we     <= 1'b0;
      pc_in     <= '0;
      data      <= '0;
      illegal   <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      alu_op    <= c.alu_op;
      dst       <= c.use_dst  ? f_dst  : '0;
      src1      <= c.use_src1 ? f_src1 : '0;
      src0      <= c.use_src0 ? f_src0 : '0;
      reg_we    <= c.reg_we;
      mem_we    <= c.mem_we;
      sel1      <= c.sel1;
      sel2      <= c.sel2;
      pc_we     <= c.pc_we;
      pc_in     <= c.pc_we ? f_imm : '0;
      data      <= c.use_imm ?
                   {{(DATA_W-IMM_W){1'b0}}, f_imm} : '0;
      illegal   <= c.illegal;
    end
  end

endmodule
